hazard_controller: RTL and testbench

Pipeline sequencing controller for the 8-bit 5-stage pipeline (IF, ID, EX, MEM, WB). Each cycle it decides the PC-stall, IF/ID-hold, IF/ID-flush and ID/EX-bubble controls, and arbitrates the single-port memory between instruction fetch and data access. It covers the load-use stall that operand forwarding cannot hide, taken-branch flush, and the multi-cycle interrupt entry sequence. It sits beside the forwarding unit and drives the pipeline-register enables and the memory address mux.

---
 rtl/hazard_controller_if.sv | 42 ++++
 rtl/hazard_controller.sv | 147 ++++++++++++++
 tb/tb_hazard_controller.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle for the hazard controller: ID/EX hazard inputs,
// interrupt request, and the stall/flush/memory-arbitration controls it drives.
interface hazard_controller_if;
  logic       id_rd_en_a;
  logic       id_rd_en_b;
  logic [1:0] id_r_add_a;
  logic [1:0] id_r_add_b;
  logic       ex_w_e_r;
  logic [1:0] ex_w_add;
  logic [2:0] ex_w_data_s;
  logic       ex_branch_taken;
  logic       mem_data_req;
  logic       irq;

  logic       stall_pc;
  logic       stall_if_id;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic       mem_grant;
  logic       push_pc;
  logic       load_vec;
  logic       irq_busy;
  logic       irq_ack;

  // Pipeline side: supplies hazard information, consumes the controls.
  modport master (
    output id_rd_en_a, id_rd_en_b, id_r_add_a, id_r_add_b,
    output ex_w_e_r, ex_w_add, ex_w_data_s, ex_branch_taken,
    output mem_data_req, irq,
    input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
    input  mem_grant, push_pc, load_vec, irq_busy, irq_ack
  );

  // Controller side.
  modport slave (
    input  id_rd_en_a, id_rd_en_b, id_r_add_a, id_r_add_b,
    input  ex_w_e_r, ex_w_add, ex_w_data_s, ex_branch_taken,
    input  mem_data_req, irq,
    output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
    output mem_grant, push_pc, load_vec, irq_busy, irq_ack
  );
endinterface

// File: rtl/hazard_controller.sv
// Sequencing controller for the 5-stage pipeline: load-use stall, branch flush,
// memory port arbitration and the drain/push/vector interrupt entry sequence.
module hazard_controller #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic               clk,
  input logic               rst_n,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {StRun, StDrain, StPush, StVec} state_e;

  localparam logic [2:0] DrainLoad = 3'(DRAIN_CYCLES - 1);
  localparam logic [1:0] RegSp     = 2'b11;
  localparam logic [2:0] SelMem    = 3'b000;

  state_e     state_q;
  logic [2:0] drain_cnt_q;
  logic       irq_q;
  logic       irq_pend_q;
  logic       irq_ack_q;

  logic match_a;
  logic match_b;
  logic load_use;
  logic irq_rise;
  logic branch;

  logic stall_pc;
  logic stall_if_id;
  logic flush_if_id;
  logic flush_id_ex;
  logic mem_grant;
  logic push_pc;
  logic load_vec;
  logic irq_busy;

  // SP reads are served by the SP unit, never by the forwarding path, so they never stall.
  assign match_a  = hz.id_rd_en_a && (hz.id_r_add_a != RegSp) && (hz.id_r_add_a == hz.ex_w_add);
  assign match_b  = hz.id_rd_en_b && (hz.id_r_add_b != RegSp) && (hz.id_r_add_b == hz.ex_w_add);
  assign load_use = hz.ex_w_e_r && (hz.ex_w_data_s == SelMem) && (match_a || match_b);
  assign irq_rise = hz.irq && !irq_q;
  assign branch   = hz.ex_branch_taken;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      drain_cnt_q <= 3'd0;
      irq_q       <= 1'b0;
      irq_pend_q  <= 1'b0;
      irq_ack_q   <= 1'b0;
    end else begin
      irq_q     <= hz.irq;
      irq_ack_q <= (state_q == StVec);
      // The acknowledge edge retires the request; any edge seen before it is merged.
      if (state_q == StVec) begin
        irq_pend_q <= 1'b0;
      end else if (irq_rise) begin
        irq_pend_q <= 1'b1;
      end

      case (state_q)
        StRun: begin
          if (irq_pend_q && !branch && !load_use) begin
            state_q     <= StDrain;
            drain_cnt_q <= DrainLoad;
          end
        end
        StDrain: begin
          // A branch resolving mid-drain redirects the PC, so the drain restarts behind it.
          if (branch) begin
            drain_cnt_q <= DrainLoad;
          end else if (drain_cnt_q == 3'd0) begin
            state_q <= StPush;
          end else begin
            drain_cnt_q <= drain_cnt_q - 3'd1;
          end
        end
        StPush:  state_q <= StVec;
        StVec:   state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    mem_grant   = 1'b0;
    push_pc     = 1'b0;
    load_vec    = 1'b0;
    irq_busy    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StRun: begin
          if (branch) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            // The MEM-stage access belongs to an older instruction and must still complete.
            mem_grant   = hz.mem_data_req;
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
            mem_grant   = hz.mem_data_req;
          end else if (hz.mem_data_req) begin
            mem_grant   = 1'b1;
            stall_pc    = 1'b1;
            flush_if_id = 1'b1;
          end
        end
        StDrain: begin
          stall_pc    = 1'b1;
          flush_if_id = 1'b1;
          irq_busy    = 1'b1;
          mem_grant   = hz.mem_data_req;
          flush_id_ex = branch;
        end
        StPush: begin
          mem_grant   = 1'b1;
          push_pc     = 1'b1;
          stall_pc    = 1'b1;
          flush_if_id = 1'b1;
          irq_busy    = 1'b1;
        end
        StVec: begin
          mem_grant   = 1'b1;
          load_vec    = 1'b1;
          flush_if_id = 1'b1;
          irq_busy    = 1'b1;
        end
      endcase
    end
  end

  assign hz.stall_pc    = stall_pc;
  assign hz.stall_if_id = stall_if_id;
  assign hz.flush_if_id = flush_if_id;
  assign hz.flush_id_ex = flush_id_ex;
  assign hz.mem_grant   = mem_grant;
  assign hz.push_pc     = push_pc;
  assign hz.load_vec    = load_vec;
  assign hz.irq_busy    = irq_busy;
  assign hz.irq_ack     = irq_ack_q && rst_n;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller with DRAIN_CYCLES=3.
// Output vector order: stall_pc stall_if_id flush_if_id flush_id_ex mem_grant push_pc load_vec irq_busy irq_ack
module tb_hazard_controller;

  localparam logic [8:0] OIdle     = 9'b000000000;
  localparam logic [8:0] OLu       = 9'b110100000;
  localparam logic [8:0] OBr       = 9'b001100000;
  localparam logic [8:0] OMem      = 9'b101010000;
  localparam logic [8:0] OLuMem    = 9'b110110000;
  localparam logic [8:0] ODrain    = 9'b101000010;
  localparam logic [8:0] ODrainBr  = 9'b101100010;
  localparam logic [8:0] ODrainMem = 9'b101010010;
  localparam logic [8:0] OPush     = 9'b101011010;
  localparam logic [8:0] OVec      = 9'b001010110;
  localparam logic [8:0] OAck      = 9'b000000001;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [8:0] outs;

  always #5 clk = ~clk;

  hazard_controller_if hz ();

  hazard_controller #(.DRAIN_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  assign outs = {hz.stall_pc, hz.stall_if_id, hz.flush_if_id, hz.flush_id_ex, hz.mem_grant,
                 hz.push_pc, hz.load_vec, hz.irq_busy, hz.irq_ack};

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_outs(input string tag, input logic [8:0] exp);
    #1;
    check_eq(tag, outs, exp);
  endtask

  task automatic clear_in();
    hz.id_rd_en_a      = 1'b0;
    hz.id_rd_en_b      = 1'b0;
    hz.id_r_add_a      = 2'b00;
    hz.id_r_add_b      = 2'b00;
    hz.ex_w_e_r        = 1'b0;
    hz.ex_w_add        = 2'b00;
    hz.ex_w_data_s     = 3'b000;
    hz.ex_branch_taken = 1'b0;
    hz.mem_data_req    = 1'b0;
  endtask

  task automatic set_load_a(input logic [1:0] wadd, input logic [1:0] radd);
    hz.ex_w_e_r    = 1'b1;
    hz.ex_w_data_s = 3'b000;
    hz.ex_w_add    = wadd;
    hz.id_rd_en_a  = 1'b1;
    hz.id_r_add_a  = radd;
  endtask

  // Raise irq from a low level and walk to the first DRAIN cycle.
  task automatic irq_start(input string tag);
    hz.irq = 1'b0;
    tick();
    hz.irq = 1'b1;
    expect_outs({tag, "_rise"}, OIdle);
    tick();
    expect_outs({tag, "_pend_run"}, OIdle);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    hz.irq = 1'b0;
    clear_in();
    hz.mem_data_req    = 1'b1;
    hz.ex_branch_taken = 1'b1;
    tick();
    tick();
    expect_outs("rst_hold", OIdle);
    clear_in();
    rst_n = 1'b1;
    tick();
    expect_outs("post_rst", OIdle);

    // Load-use and its non-stalling variants.
    set_load_a(2'b01, 2'b01);
    expect_outs("lu_a", OLu);
    tick();
    clear_in();
    expect_outs("lu_one_cycle", OIdle);
    set_load_a(2'b11, 2'b11);
    expect_outs("lu_sp_exempt", OIdle);
    tick();
    clear_in();
    hz.ex_w_e_r    = 1'b1;
    hz.ex_w_add    = 2'b10;
    hz.id_rd_en_b  = 1'b1;
    hz.id_r_add_b  = 2'b10;
    expect_outs("lu_b", OLu);
    hz.ex_w_data_s = 3'b001;
    expect_outs("alu_no_stall", OIdle);
    tick();
    clear_in();
    set_load_a(2'b10, 2'b10);
    hz.id_rd_en_a = 1'b0;
    expect_outs("lu_no_rd_en", OIdle);
    tick();
    clear_in();
    set_load_a(2'b01, 2'b01);
    hz.ex_branch_taken = 1'b1;
    expect_outs("br_beats_lu", OBr);
    tick();
    clear_in();
    hz.mem_data_req = 1'b1;
    expect_outs("mem_req", OMem);
    set_load_a(2'b01, 2'b01);
    expect_outs("lu_mem", OLuMem);
    tick();
    clear_in();

    // Quiet-pipeline interrupt entry, irq held high afterward.
    irq_start("irq");
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_outs("irq_drain", ODrain);
    end
    tick();
    expect_outs("irq_push", OPush);
    tick();
    expect_outs("irq_vec", OVec);
    tick();
    expect_outs("irq_ack", OAck);
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_outs("irq_held", OIdle);
    end

    // Branch defers DRAIN entry, then restarts the drain from its 2nd cycle.
    irq_start("rst_br");
    hz.ex_branch_taken = 1'b1;
    expect_outs("defer_br", OBr);
    tick();
    hz.ex_branch_taken = 1'b0;
    expect_outs("defer_quiet", OIdle);
    tick();
    expect_outs("br_d1", ODrain);
    tick();
    hz.ex_branch_taken = 1'b1;
    expect_outs("br_d2", ODrainBr);
    tick();
    hz.ex_branch_taken = 1'b0;
    expect_outs("br_d3", ODrain);
    tick();
    hz.mem_data_req = 1'b1;
    expect_outs("br_d4_mem", ODrainMem);
    tick();
    hz.mem_data_req = 1'b0;
    expect_outs("br_d5", ODrain);
    tick();
    expect_outs("br_push", OPush);
    tick();
    expect_outs("br_vec", OVec);
    tick();
    expect_outs("br_ack", OAck);

    // Reset during PUSH aborts the sequence.
    irq_start("abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_outs("abort_drain", ODrain);
    end
    tick();
    expect_outs("abort_push", OPush);
    rst_n  = 1'b0;
    hz.irq = 1'b0;
    expect_outs("abort_forced", OIdle);
    tick();
    rst_n = 1'b1;
    expect_outs("abort_run", OIdle);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_outs("abort_no_vec_ack", OIdle);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
